// File: rtl/cache_sram_init_bist.sv
// Init / March self-test sequencer owning port 0 of one OpenRAM macro, then
// handing the port to the cache wrapper as a combinational pass-through.
module cache_sram_init_bist #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4,
  parameter int DEPTH  = 512
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  input  logic              c_csb0,
  input  logic              c_web0,
  input  logic [MASK_W-1:0] c_wmask0,
  input  logic [ADDR_W-1:0] c_addr0,
  input  logic [DATA_W-1:0] c_din0,
  output logic [DATA_W-1:0] c_dout0,
  output logic              m_clk,
  output logic              m_csb0,
  output logic              m_web0,
  output logic [MASK_W-1:0] m_wmask0,
  output logic [ADDR_W-1:0] m_addr0,
  output logic [DATA_W-1:0] m_din0,
  input  logic [DATA_W-1:0] m_dout0,
  output logic              m_csb1,
  output logic [ADDR_W-1:0] m_addr1,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_RST, S_ZFILL, S_P1, S_P2, S_P3, S_P4, S_PLAST, S_DONE
  } state_t;

  localparam logic [DATA_W-1:0] PA   = {(DATA_W/2){2'b10}};
  localparam logic [DATA_W-1:0] PB   = ~PA;
  localparam logic [ADDR_W:0]   LAST = (ADDR_W+1)'(DEPTH-1);

  state_t              r_state;
  logic [ADDR_W:0]     r_addr;
  logic                r_phase;
  logic                r_p4_vld;
  logic                r_fail;
  logic [ADDR_W-1:0]   r_fail_addr;

  state_t              w_state;
  state_t              w_next_state;
  logic [ADDR_W:0]     w_next_addr;
  logic                w_next_phase;
  logic                w_next_p4_vld;
  logic                w_last;
  logic                w_cmp;
  logic [DATA_W-1:0]   w_cmp_exp;
  logic [ADDR_W-1:0]   w_cmp_addr;
  logic                w_clear;
  logic                w_seq_csb;
  logic                w_seq_web;
  logic [DATA_W-1:0]   w_seq_din;

  // RST with reset low is the first sequencing cycle, so the mode is taken
  // straight from the pin and busy rises with no dead cycle.
  always_comb begin
    w_state = r_state;
    if (reset)
      w_state = S_RST;
    else if (r_state == S_RST)
      w_state = mode ? S_P1 : S_ZFILL;
  end

  assign w_last = (r_addr == LAST);

  always_comb begin
    w_next_state  = w_state;
    w_next_addr   = r_addr;
    w_next_phase  = r_phase;
    w_next_p4_vld = 1'b0;
    w_cmp         = 1'b0;
    w_cmp_exp     = '0;
    w_cmp_addr    = r_addr[ADDR_W-1:0];
    w_clear       = 1'b0;
    w_seq_csb     = 1'b1;
    w_seq_web     = 1'b1;
    w_seq_din     = '0;
    case (w_state)
      S_ZFILL, S_P1: begin
        w_seq_csb   = 1'b0;
        w_seq_web   = 1'b0;
        w_seq_din   = (w_state == S_P1) ? PA : '0;
        w_next_addr = w_last ? '0 : r_addr + (ADDR_W+1)'(1);
        if (w_last)
          w_next_state = (w_state == S_P1) ? S_P2 : S_DONE;
      end
      S_P2, S_P3: begin
        w_seq_csb    = 1'b0;
        w_next_phase = ~r_phase;
        // Second cycle of a read-modify-write: dout holds the first-cycle read
        if (r_phase) begin
          w_seq_web   = 1'b0;
          w_seq_din   = (w_state == S_P2) ? PB : '0;
          w_cmp       = 1'b1;
          w_cmp_exp   = (w_state == S_P2) ? PA : PB;
          w_next_addr = w_last ? '0 : r_addr + (ADDR_W+1)'(1);
          if (w_last)
            w_next_state = (w_state == S_P2) ? S_P3 : S_P4;
        end
      end
      S_P4: begin
        w_seq_csb     = 1'b0;
        w_next_p4_vld = 1'b1;
        w_cmp         = r_p4_vld;
        w_cmp_addr    = r_addr[ADDR_W-1:0] - ADDR_W'(1);
        w_next_addr   = w_last ? '0 : r_addr + (ADDR_W+1)'(1);
        if (w_last)
          w_next_state = S_PLAST;
      end
      S_PLAST: begin
        w_cmp        = 1'b1;
        w_cmp_addr   = LAST[ADDR_W-1:0];
        w_next_state = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          w_next_state = mode ? S_P1 : S_ZFILL;
          w_next_addr  = '0;
          w_next_phase = 1'b0;
          w_clear      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_RST;
      r_addr      <= '0;
      r_phase     <= 1'b0;
      r_p4_vld    <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
    end else begin
      r_state  <= w_next_state;
      r_addr   <= w_next_addr;
      r_phase  <= w_next_phase;
      r_p4_vld <= w_next_p4_vld;
      if (w_clear) begin
        r_fail      <= 1'b0;
        r_fail_addr <= '0;
      end else if (w_cmp && (m_dout0 != w_cmp_exp) && !r_fail) begin
        r_fail      <= 1'b1;
        r_fail_addr <= w_cmp_addr;
      end
    end
  end

  assign busy      = (w_state != S_RST) && (w_state != S_DONE);
  assign done      = (w_state == S_DONE);
  assign fail      = r_fail & ~reset;
  assign fail_addr = reset ? '0 : r_fail_addr;
  assign dbg_state = w_state;

  assign m_clk   = clock;
  assign c_dout0 = m_dout0;
  assign m_csb1  = 1'b1;
  assign m_addr1 = '1;

  always_comb begin
    m_csb0   = 1'b1;
    m_web0   = 1'b1;
    m_wmask0 = '0;
    m_addr0  = '0;
    m_din0   = '0;
    if (w_state == S_DONE) begin
      m_csb0   = c_csb0;
      m_web0   = c_web0;
      m_wmask0 = c_wmask0;
      m_addr0  = c_addr0;
      m_din0   = c_din0;
    end else if (busy) begin
      m_csb0   = w_seq_csb;
      m_web0   = w_seq_web;
      m_wmask0 = '1;
      m_addr0  = r_addr[ADDR_W-1:0];
      m_din0   = w_seq_din;
    end
  end

endmodule

// File: tb/tb_cache_sram_init_bist.sv
// Bench for cache_sram_init_bist: behavioural macro with optional stuck bit,
// write/read scoreboards and cycle-accurate completion checks.
module tb_cache_sram_init_bist;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;
  localparam int DEPTH  = 512;
  localparam int W      = ADDR_W + DATA_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              mode  = 1'b0;
  logic              busy, done, fail;
  logic [ADDR_W-1:0] fail_addr;
  logic              c_csb0 = 1'b1;
  logic              c_web0 = 1'b1;
  logic [MASK_W-1:0] c_wmask0 = '0;
  logic [ADDR_W-1:0] c_addr0 = '0;
  logic [DATA_W-1:0] c_din0 = '0;
  logic [DATA_W-1:0] c_dout0;
  logic              m_clk, m_csb0, m_web0, m_csb1;
  logic [MASK_W-1:0] m_wmask0;
  logic [ADDR_W-1:0] m_addr0, m_addr1;
  logic [DATA_W-1:0] m_din0;
  logic [DATA_W-1:0] m_dout0 = '0;
  logic [2:0]        dbg_state;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0]      exp_q[$];
  logic [DATA_W-1:0] rd_q[$];
  logic              sb_en    = 1'b0;
  logic              fault_en = 1'b0;
  logic              mem_init = 1'b0;
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  cache_sram_init_bist #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
    .c_csb0(c_csb0), .c_web0(c_web0), .c_wmask0(c_wmask0),
    .c_addr0(c_addr0), .c_din0(c_din0), .c_dout0(c_dout0),
    .m_clk(m_clk), .m_csb0(m_csb0), .m_web0(m_web0), .m_wmask0(m_wmask0),
    .m_addr0(m_addr0), .m_din0(m_din0), .m_dout0(m_dout0),
    .m_csb1(m_csb1), .m_addr1(m_addr1), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Macro model: byte-lane masked writes, registered read data, optional
  // bit 3 stuck-at-0 at address 0x17F.
  always @(posedge m_clk) begin
    logic [DATA_W-1:0] w;
    if (!mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      mem_init = 1'b1;
    end
    if (!m_csb0) begin
      if (!m_web0) begin
        w = mem[m_addr0];
        for (int b = 0; b < MASK_W; b++)
          if (m_wmask0[b]) w[b*8 +: 8] = m_din0[b*8 +: 8];
        if (fault_en && m_addr0 == 9'h17F) w[3] = 1'b0;
        mem[m_addr0] = w;
      end else begin
        m_dout0 <= mem[m_addr0];
      end
    end
  end

  // Write monitor: pops one expected {addr,data} per observed macro write
  always @(negedge clock) begin
    if (sb_en && !reset && !m_csb0 && !m_web0) begin
      if (exp_q.size() == 0) begin
        check("wr_extra", 1, 0);
      end else begin
        check("seq_wr", {m_addr0, m_din0}, exp_q.pop_front());
        check("seq_mask", m_wmask0, 4'hF);
      end
    end
  end

  // Driver tasks
  task automatic apply_reset(input logic m);
    @(posedge clock); #1;
    reset = 1'b1;
    mode  = m;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic c_idle();
    c_csb0 = 1'b1; c_web0 = 1'b1; c_wmask0 = '0; c_addr0 = '0; c_din0 = '0;
  endtask

  task automatic c_junk();
    c_csb0 = 1'b0; c_web0 = 1'b0; c_wmask0 = 4'hF;
    c_addr0 = 9'h055; c_din0 = 32'h1234_5678;
  endtask

  // Called at the negedge of cycle 0; returns the cycle in which done is seen
  // and the first cycle in which fail is seen (-1 if never).
  task automatic wait_done(input int bound, input int start_at, output int cyc, output int fcyc);
    cyc  = 0;
    fcyc = fail ? 0 : -1;
    while (!done && cyc < bound) begin
      @(negedge clock);
      cyc++;
      if (start_at >= 0) start = (cyc == start_at);
      if (fail && fcyc < 0) fcyc = cyc;
    end
    start = 1'b0;
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic check_mem_zero(input string tag);
    int nz = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== '0) nz++;
    check(tag, nz, 0);
  endtask

  int cyc, fcyc;

  initial begin
    // Reset state, with the wrapper trying to drive the macro
    c_junk();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fail", fail, 0);
    check("rst_fail_addr", fail_addr, 0);
    check("rst_csb0", m_csb0, 1);
    check("rst_web0", m_web0, 1);
    check("rst_wmask0", m_wmask0, 0);
    check("rst_addr0", m_addr0, 0);
    check("rst_din0", m_din0, 0);
    check("rst_csb1", m_csb1, 1);
    check("rst_addr1", m_addr1, 9'h1FF);

    // Zero-fill, wrapper requests dropped, stray start at cycle 100 ignored
    for (int a = 0; a < DEPTH; a++) exp_q.push_back({9'(a), 32'h0});
    sb_en = 1'b1;
    @(posedge clock); #1 reset = 1'b0; mode = 1'b0;
    @(negedge clock);
    check("zf_busy0", busy, 1);
    wait_done(4000, 100, cyc, fcyc);
    c_idle();
    sb_en = 1'b0;
    check("zf_done_cyc", cyc, DEPTH);
    check("zf_busy_end", busy, 0);
    check("zf_fail", fail, 0);
    check("zf_sb_left", exp_q.size(), 0);
    check_mem_zero("zf_mem_zero");

    // Full March against an ideal macro
    apply_reset(1'b1);
    check("m1_busy0", busy, 1);
    check("m1_p1_wr0", {m_csb0, m_web0, m_addr0, m_din0}, {1'b0, 1'b0, 9'h0, 32'hAAAA_AAAA});
    wait_done(8000, -1, cyc, fcyc);
    check("m1_done_cyc", cyc, 6*DEPTH + 1);
    check("m1_fail", fail, 0);
    check_mem_zero("m1_mem_zero");

    // Wrapper pass-through in DONE: write then read back
    c_csb0 = 1'b0; c_web0 = 1'b0; c_wmask0 = 4'hF;
    c_addr0 = 9'h005; c_din0 = 32'hDEAD_BEEF;
    #1;
    check("pt_wr", {m_csb0, m_web0, m_wmask0, m_addr0, m_din0},
          {1'b0, 1'b0, 4'hF, 9'h005, 32'hDEAD_BEEF});
    @(negedge clock);
    c_web0 = 1'b1;
    rd_q.push_back(32'hDEAD_BEEF);
    #1;
    check("pt_rd", {m_csb0, m_web0, m_addr0}, {1'b0, 1'b1, 9'h005});
    @(negedge clock);
    c_idle();
    if (rd_q.size() == 0) check("pt_rd_q", 0, 1);
    else check("pt_dout", c_dout0, rd_q.pop_front());
    check("pt_mem5", mem[5], 32'hDEAD_BEEF);

    // March with bit 3 stuck-at-0 at 0x17F: P2 compare fails
    fault_en = 1'b1;
    apply_reset(1'b1);
    wait_done(8000, -1, cyc, fcyc);
    check("flt_done_cyc", cyc, 6*DEPTH + 1);
    check("flt_fail", fail, 1);
    check("flt_fail_addr", fail_addr, 9'h17F);
    check("flt_fail_cyc", fcyc, DEPTH + 2*'h17F + 2);
    fault_en = 1'b0;

    // start in DONE with a recorded failure, zero-fill mode
    start = 1'b1; mode = 1'b0;
    @(negedge clock);
    start = 1'b0;
    check("st_state", {done, fail, busy, fail_addr}, {1'b0, 1'b0, 1'b1, 9'h0});
    check("st_addr0", {m_csb0, m_web0, m_addr0}, {1'b0, 1'b0, 9'h0});
    wait_done(4000, -1, cyc, fcyc);
    check("st_done_cyc", cyc, DEPTH);
    check_mem_zero("st_mem_zero");

    // Reset mid-March aborts; restart behaves as a cold start
    apply_reset(1'b1);
    repeat (199) @(negedge clock);
    @(posedge clock); #1 reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("mr_csb0", m_csb0, 1);
      check("mr_busy", {busy, done}, 2'b00);
    end
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("mr_restart", {busy, m_csb0, m_web0, m_addr0}, {1'b1, 1'b0, 1'b0, 9'h0});
    wait_done(8000, -1, cyc, fcyc);
    check("mr_done_cyc", cyc, 6*DEPTH + 1);
    check("mr_fail", fail, 0);
    check_mem_zero("mr_mem_zero");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
